spi_regfile_slave: RTL

//  SPI mode-1 (CPOL=0, CPHA=1) slave giving an external master access to a parametrised register file.

---
 rtl/spi_regfile_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_regfile_slave.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spi_regfile_pkg.sv
// Shared FSM type, command-word constants and address helper for the SPI register-file slave.
package spi_regfile_pkg;

    typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} spi_state_t;

    localparam int unsigned CMD_W      = 8;
    localparam int unsigned CMD_RD_BIT = 7;
    localparam logic [6:0]  ADDR_MASK  = 7'h7F;

    // Burst address step: the top register wraps back to 0.
    function automatic logic [6:0] next_addr(input logic [6:0] addr, input int unsigned num_regs);
        return (32'(addr) == num_regs - 1) ? 7'd0 : addr + 7'd1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for one asynchronous input, with rise/fall strobes taken from the
// last two synchronised samples. Strobes stay quiet until the chain holds only real samples.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES:0] r_sync;
    logic [STAGES:0] r_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {(STAGES + 1){RST_VAL}};
            r_vld  <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-1:0], i_d};
            r_vld  <= {r_vld[STAGES-1:0], 1'b1};
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_vld[STAGES] &  r_sync[STAGES-1] & ~r_sync[STAGES];
    assign o_fall  = r_vld[STAGES] & ~r_sync[STAGES-1] &  r_sync[STAGES];

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI mode-1 slave exposing a register file (address 0 = read-only ID), fully clocked by clk.
// Define SPI_BURST_EN to let a frame run multiple words with auto-incrementing address.
//  5 SPI_BURST_EN: write cmd 8'h06 + 8'h11,8'h22,8'h33 -> reg6=8'h11, reg7=8'h22; 3rd word wraps to RO addr 0,
//    dropped; exactly 2 pulses (wr_addr_o 6,7). Without the macro: only reg6=8'h11, one pulse.
module spi_regfile_slave
    import spi_regfile_pkg::*;
#(
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       NUM_REGS    = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] ID_VALUE    = 8'h96
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         mosi,
    input  logic                         cs_n,
    output logic                         miso,
    output logic                         miso_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    output logic                         wr_pulse_o,
    output logic [6:0]                   wr_addr_o
);

    localparam int unsigned CNT_W = $clog2(((DATA_W > CMD_W) ? DATA_W : CMD_W) + 1);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;
    logic w_wr_ok;
    logic [CMD_W-1:0] w_cmd_full;

    spi_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CMD_W-2:0]  r_cmd;
    logic [6:0]        r_addr;
    logic [DATA_W-1:0] r_shift;
    logic              r_load, r_wr_pend, r_done, r_miso, r_wr_pulse;
    logic [6:0]        r_wr_addr;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(sclk),
        .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(cs_n),
        .o_level(w_cs_lvl), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(clk), .i_rst_n(rst_n), .i_d(mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_sclk_lvl, w_cs_rise, w_mosi_rise, w_mosi_fall};

    function automatic logic [DATA_W-1:0] rd_val(input logic [6:0] a);
        if (a == 7'd0) return ID_VALUE;
        if (32'(a) >= NUM_REGS) return '0;
        return r_regs[a[IDX_W-1:0]];
    endfunction

    assign w_cmd_full = {r_cmd, w_mosi};
    assign w_wr_ok    = (r_addr != 7'd0) && (32'(r_addr) < NUM_REGS);

`ifdef SPI_BURST_EN
    logic [DATA_W-1:0] w_rd_nxt;
    assign w_rd_nxt = rd_val(next_addr(r_addr, NUM_REGS));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_cmd      <= '0;
            r_addr     <= '0;
            r_shift    <= '0;
            r_load     <= 1'b0;
            r_wr_pend  <= 1'b0;
            r_done     <= 1'b0;
            r_miso     <= 1'b0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_regs     <= '{default: '0};
        end else begin
            r_wr_pulse <= 1'b0;
            r_load     <= 1'b0;
            r_wr_pend  <= 1'b0;
            if (r_load) r_shift <= rd_val(r_addr);
            // A completed word commits even if cs_n is already on its way up.
            if (r_wr_pend) begin
                if (w_wr_ok) begin
                    r_regs[r_addr[IDX_W-1:0]] <= r_shift;
                    r_wr_pulse                <= 1'b1;
                    r_wr_addr                 <= r_addr;
                end
`ifdef SPI_BURST_EN
                r_addr <= next_addr(r_addr, NUM_REGS);
`endif
            end
            if (w_cs_lvl) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_miso  <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (w_cs_fall) begin
                            r_state <= CMD;
                            r_cnt   <= '0;
                        end
                    end
                    CMD: begin
                        if (w_sclk_fall) begin
                            r_cmd <= w_cmd_full[CMD_W-2:0];
                            if (r_cnt == CNT_W'(CMD_W - 1)) begin
                                r_addr  <= w_cmd_full[6:0] & ADDR_MASK;
                                r_cnt   <= '0;
                                r_state <= w_cmd_full[CMD_RD_BIT] ? RDATA : WDATA;
                                r_load  <= w_cmd_full[CMD_RD_BIT];
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    RDATA: begin
                        if (w_sclk_rise && !r_done) begin
                            if (r_cnt < CNT_W'(DATA_W)) begin
                                r_miso  <= r_shift[DATA_W-1];
                                r_shift <= r_shift << 1;
                                r_cnt   <= r_cnt + CNT_W'(1);
                            end else begin
`ifdef SPI_BURST_EN
                                r_miso  <= w_rd_nxt[DATA_W-1];
                                r_shift <= w_rd_nxt << 1;
                                r_addr  <= next_addr(r_addr, NUM_REGS);
                                r_cnt   <= CNT_W'(1);
`else
                                r_miso  <= 1'b0;
                                r_done  <= 1'b1;
`endif
                            end
                        end
                    end
                    WDATA: begin
                        if (w_sclk_fall && !r_done) begin
                            r_shift <= {r_shift[DATA_W-2:0], w_mosi};
                            if (r_cnt == CNT_W'(DATA_W - 1)) begin
                                r_wr_pend <= 1'b1;
`ifdef SPI_BURST_EN
                                r_cnt     <= '0;
`else
                                r_done    <= 1'b1;
`endif
                            end else begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign regs_o[0 +: DATA_W] = ID_VALUE;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs
        assign regs_o[g*DATA_W +: DATA_W] = r_regs[g];
    end

    assign miso       = r_miso;
    assign miso_oe    = ~w_cs_lvl;
    assign wr_pulse_o = r_wr_pulse;
    assign wr_addr_o  = r_wr_addr;

endmodule
